// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: row synchronizer, column scan, frame debounce, cmd encoding.
// Define KEYPAD_AUTO_REPEAT_EN to add auto-repeat pulses for held digit keys.
module keypad_scan #(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CNT = 4,
  parameter int unsigned REPEAT_DELAY = 40,
  parameter int unsigned REPEAT_RATE  = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {StIdle, StDebPress, StHeld, StDebRel} state_e;

  localparam int unsigned DivW = $clog2(SCAN_DIV);
  localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CNT);

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("keypad_scan: SCAN_DIV must be >= 2");
  end
  if (DEBOUNCE_CNT < 1) begin : g_bad_debounce
    $error("keypad_scan: DEBOUNCE_CNT must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_repeat
    $error("keypad_scan: REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    unique case ({r, c})
      4'h0: code = 4'b0001;
      4'h1: code = 4'b0010;
      4'h2: code = 4'b0011;
      4'h3: code = 4'b1010;
      4'h4: code = 4'b0100;
      4'h5: code = 4'b0101;
      4'h6: code = 4'b0110;
      4'h7: code = 4'b1011;
      4'h8: code = 4'b0111;
      4'h9: code = 4'b1000;
      4'ha: code = 4'b1001;
      4'hb: code = 4'b1100;
      4'hc: code = 4'b1111;
      4'hd: code = 4'b0000;
      4'he: code = 4'b1110;
      default: code = 4'b1101;
    endcase
    return code;
  endfunction

  // Rows idle high (external pull-ups), so the synchronizer resets to all ones.
  logic [3:0] row_meta_q, row_sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_meta_q <= 4'hf;
      row_sync_q <= 4'hf;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  logic [DivW-1:0] div_q;
  logic [1:0]      col_idx_q;
  logic            sample, frame_end;

  assign sample    = (div_q == DivLast);
  assign frame_end = sample && (col_idx_q == 2'd3);
  assign col       = ~(4'b0001 << col_idx_q);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q     <= '0;
      col_idx_q <= '0;
    end else if (sample) begin
      div_q     <= '0;
      col_idx_q <= col_idx_q + 2'd1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  logic [2:0] slot_n;
  logic [1:0] slot_row;

  always_comb begin
    slot_n   = '0;
    slot_row = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync_q[i]) begin
        slot_n   = slot_n + 3'd1;
        slot_row = 2'(i);
      end
    end
  end

  // Per-frame accumulation; totals include the slot being sampled this cycle.
  logic       acc_one_q, acc_multi_q;
  logic [1:0] acc_row_q, acc_col_q;
  logic       tot_one, tot_multi;
  logic [1:0] tot_row, tot_col;
  logic [3:0] key_code;
  logic       is_one, is_none;

  assign tot_multi = acc_multi_q || (slot_n > 3'd1) || (acc_one_q && (slot_n != 3'd0));
  assign tot_one   = !tot_multi && (acc_one_q || (slot_n == 3'd1));
  assign tot_row   = acc_one_q ? acc_row_q : slot_row;
  assign tot_col   = acc_one_q ? acc_col_q : col_idx_q;
  assign key_code  = key_map(tot_row, tot_col);
  assign is_one    = tot_one && (key_code != 4'b1101);
  assign is_none   = !tot_multi && !is_one;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_one_q   <= 1'b0;
      acc_multi_q <= 1'b0;
      acc_row_q   <= '0;
      acc_col_q   <= '0;
    end else if (sample) begin
      if (col_idx_q == 2'd3) begin
        acc_one_q   <= 1'b0;
        acc_multi_q <= 1'b0;
      end else begin
        acc_one_q   <= tot_one;
        acc_multi_q <= tot_multi;
        acc_row_q   <= tot_row;
        acc_col_q   <= tot_col;
      end
    end
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      cand_q, cand_d, cmd_q, cmd_d;
  logic            cmd_valid_q, accept, pulse;

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        StIdle: begin
          if (is_one) begin
            cand_d = key_code;
            if (DEBOUNCE_CNT == 1) begin
              accept = 1'b1;
            end else begin
              cnt_d   = CntW'(1);
              state_d = StDebPress;
            end
          end
        end
        StDebPress: begin
          if (is_one && (key_code == cand_q)) begin
            if (cnt_inc == CntLast) accept = 1'b1;
            else cnt_d = cnt_inc;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StHeld: begin
          if (is_none) begin
            if (DEBOUNCE_CNT == 1) begin
              state_d = StIdle;
            end else begin
              cnt_d   = CntW'(1);
              state_d = StDebRel;
            end
          end
        end
        StDebRel: begin
          if (is_none) begin
            if (cnt_inc == CntLast) begin
              state_d = StIdle;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StHeld;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
      if (accept) begin
        state_d = StHeld;
        cnt_d   = '0;
      end
    end
  end

  assign cmd_d = accept ? key_code : cmd_q;

`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);
  localparam logic [RepW-1:0] RepDelay = RepW'(REPEAT_DELAY);
  localparam logic [RepW-1:0] RepRate  = RepW'(REPEAT_RATE);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
  logic            rep_first_q, rep_first_d, rep_fire;

  assign rep_inc = rep_cnt_q + 1'b1;

  // Counts frames spent in HELD; first threshold is the delay, then the rate.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_fire    = 1'b0;
    if (accept || (state_q == StHeld && state_d != StHeld)) begin
      rep_cnt_d   = '0;
      rep_first_d = 1'b1;
    end else if (frame_end && state_q == StHeld && cmd_q <= 4'd9) begin
      if (rep_inc == (rep_first_q ? RepDelay : RepRate)) begin
        rep_fire    = 1'b1;
        rep_cnt_d   = '0;
        rep_first_d = 1'b0;
      end else begin
        rep_cnt_d = rep_inc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
    end
  end

  assign pulse = accept || rep_fire;
`else
  assign pulse = accept;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cand_q      <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= pulse;
    end
  end

  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign key_held  = (state_q == StHeld) || (state_q == StDebRel);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=3 (16-cycle frames).
// Auto-repeat scenario runs only when KEYPAD_AUTO_REPEAT_EN is defined.
module tb_keypad_scan;

  localparam int unsigned Frame = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row, col, cmd;
  logic        cmd_valid, key_held;
  logic [15:0] pressed = '0;  // bit r*4+c set while key (r,c) is down

  int          n_cmp = 0;
  int          n_fail = 0;
  int          pulse_cnt = 0;
  int unsigned cyc;

  always #5 clock = ~clock;

  keypad_scan #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(3),
    .REPEAT_DELAY(5),
    .REPEAT_RATE (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .cmd      (cmd),
    .cmd_valid(cmd_valid),
    .key_held (key_held)
  );

  // A row reads low when a pressed key sits on the column currently driven low.
  always_comb begin
    row = 4'hf;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge clock) begin
    if (reset && cmd_valid) pulse_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic align_frame();
    @(negedge clock);
    for (int i = 0; i < Frame && (cyc % Frame) != 0; i++) @(negedge clock);
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    reset = 1'b0;
    pressed = '0;
    step(3);
    #1;
    n_cmp++; if (col !== 4'b1110) begin n_fail++; $display("FAIL reset_col: got %b want 1110", col); end
    n_cmp++; if (cmd !== 4'b0000) begin n_fail++; $display("FAIL reset_cmd: got %b want 0000", cmd); end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", cmd_valid); end
    n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held: got %b want 0", key_held); end
    reset = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      n_cmp++;
      if (col !== exp_col) begin
        n_fail++;
        $display("FAIL scan_col cycle %0d: got %b want %b", k, col, exp_col);
      end
      @(negedge clock);
      #1;
    end
    n_cmp++; if (pulse_cnt !== 0) begin n_fail++; $display("FAIL idle_pulses: got %0d want 0", pulse_cnt); end
  endtask

  task automatic test_single_press();
    int p0;
    align_frame();
    p0 = pulse_cnt;
    pressed = '0;
    pressed[5] = 1'b1;  // key 5
    step(47);
    #1;
    n_cmp++; if (pulse_cnt !== p0) begin n_fail++; $display("FAIL k5_early: got %0d want %0d", pulse_cnt, p0); end
    @(negedge clock);
    #1;
    n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL k5_valid: got %b want 1", cmd_valid); end
    n_cmp++; if (cmd !== 4'b0101) begin n_fail++; $display("FAIL k5_cmd: got %b want 0101", cmd); end
    n_cmp++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL k5_held: got %b want 1", key_held); end
    @(negedge clock);
    #1;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL k5_one_cycle: got %b want 0", cmd_valid); end
    step(27 * Frame - 1);
    #1;
    n_cmp++; if (pulse_cnt !== p0 + 1) begin n_fail++; $display("FAIL k5_count: got %0d want %0d", pulse_cnt, p0 + 1); end
    n_cmp++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL k5_still_held: got %b want 1", key_held); end
    align_frame();
    pressed = '0;
    step(47);
    #1;
    n_cmp++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL k5_rel_early: got %b want 1", key_held); end
    @(negedge clock);
    #1;
    n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL k5_released: got %b want 0", key_held); end
  endtask

  task automatic test_bounce();
    int p0;
    align_frame();
    p0 = pulse_cnt;
    pressed[8] = 1'b1;  // key 7
    step(2 * Frame);
    pressed = '0;
    step(Frame);
    pressed[8] = 1'b1;
    step(47);
    #1;
    n_cmp++; if (pulse_cnt !== p0) begin n_fail++; $display("FAIL k7_early: got %0d want %0d", pulse_cnt, p0); end
    @(negedge clock);
    #1;
    n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL k7_valid: got %b want 1", cmd_valid); end
    n_cmp++; if (cmd !== 4'b0111) begin n_fail++; $display("FAIL k7_cmd: got %b want 0111", cmd); end
    pressed = '0;
    step(4 * Frame);
    #1;
    n_cmp++; if (pulse_cnt !== p0 + 1) begin n_fail++; $display("FAIL k7_count: got %0d want %0d", pulse_cnt, p0 + 1); end
    n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL k7_released: got %b want 0", key_held); end
  endtask

  task automatic test_multi();
    int p0;
    align_frame();
    p0 = pulse_cnt;
    pressed[0] = 1'b1;  // key 1
    pressed[1] = 1'b1;  // key 2
    step(10 * Frame);
    #1;
    n_cmp++; if (pulse_cnt !== p0) begin n_fail++; $display("FAIL multi_nopulse: got %0d want %0d", pulse_cnt, p0); end
    n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL multi_held: got %b want 0", key_held); end
    pressed[1] = 1'b0;
    step(48);
    #1;
    n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL k1_valid: got %b want 1", cmd_valid); end
    n_cmp++; if (cmd !== 4'b0001) begin n_fail++; $display("FAIL k1_cmd: got %b want 0001", cmd); end
    pressed = '0;
    step(4 * Frame);
  endtask

  task automatic test_no_repress();
    int p0;
    align_frame();
    p0 = pulse_cnt;
    pressed[5] = 1'b1;
    step(48);
    #1;
    n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rp5_valid: got %b want 1", cmd_valid); end
    pressed = '0;
    step(2 * Frame);
    pressed[5] = 1'b1;
    step(3 * Frame);
    #1;
    n_cmp++; if (pulse_cnt !== p0 + 1) begin n_fail++; $display("FAIL rp5_no_repulse: got %0d want %0d", pulse_cnt, p0 + 1); end
    n_cmp++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL rp5_held: got %b want 1", key_held); end
    pressed = '0;
    step(3 * Frame);
    #1;
    n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL rp5_released: got %b want 0", key_held); end
    pressed[3] = 1'b1;  // key +
    step(47);
    #1;
    n_cmp++; if (pulse_cnt !== p0 + 1) begin n_fail++; $display("FAIL plus_early: got %0d want %0d", pulse_cnt, p0 + 1); end
    @(negedge clock);
    #1;
    n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL plus_valid: got %b want 1", cmd_valid); end
    n_cmp++; if (cmd !== 4'b1010) begin n_fail++; $display("FAIL plus_cmd: got %b want 1010", cmd); end
    pressed = '0;
    step(4 * Frame);
    pressed[15] = 1'b1;  // spare key
    step(10 * Frame);
    #1;
    n_cmp++; if (pulse_cnt !== p0 + 2) begin n_fail++; $display("FAIL spare_nopulse: got %0d want %0d", pulse_cnt, p0 + 2); end
    n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL spare_held: got %b want 0", key_held); end
    n_cmp++; if (cmd !== 4'b1010) begin n_fail++; $display("FAIL cmd_holds: got %b want 1010", cmd); end
    pressed = '0;
    step(Frame);
  endtask

  task automatic test_reset_mid();
    int p0;
    align_frame();
    p0 = pulse_cnt;
    pressed[10] = 1'b1;  // key 9
    step(2 * Frame + 5);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (col !== 4'b1110) begin n_fail++; $display("FAIL rst_mid_col: got %b want 1110", col); end
    n_cmp++; if (cmd !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_cmd: got %b want 0000", cmd); end
    n_cmp++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", cmd_valid); end
    n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL rst_mid_held: got %b want 0", key_held); end
    step(3);
    reset = 1'b1;
    step(47);
    #1;
    n_cmp++; if (pulse_cnt !== p0) begin n_fail++; $display("FAIL rst_discard: got %0d want %0d", pulse_cnt, p0); end
    @(negedge clock);
    #1;
    n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL k9_valid: got %b want 1", cmd_valid); end
    n_cmp++; if (cmd !== 4'b1001) begin n_fail++; $display("FAIL k9_cmd: got %b want 1001", cmd); end
    pressed = '0;
    step(4 * Frame);
  endtask

`ifdef KEYPAD_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    int p0;
    align_frame();
    p0 = pulse_cnt;
    pressed[9] = 1'b1;  // key 8
    step(48);
    #1;
    n_cmp++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL rep_accept: got %b want 1", cmd_valid); end
    step(79);
    #1;
    n_cmp++; if (pulse_cnt !== p0 + 1) begin n_fail++; $display("FAIL rep_early: got %0d want %0d", pulse_cnt, p0 + 1); end
    @(negedge clock);
    #1;
    n_cmp++; if (cmd_valid !== 1'b1 || cmd !== 4'b1000) begin n_fail++; $display("FAIL rep_5: got %b/%b want 1/1000", cmd_valid, cmd); end
    step(32);
    #1;
    n_cmp++; if (cmd_valid !== 1'b1 || cmd !== 4'b1000) begin n_fail++; $display("FAIL rep_7: got %b/%b want 1/1000", cmd_valid, cmd); end
    step(32);
    #1;
    n_cmp++; if (cmd_valid !== 1'b1 || cmd !== 4'b1000) begin n_fail++; $display("FAIL rep_9: got %b/%b want 1/1000", cmd_valid, cmd); end
    step(16);
    pressed = '0;
    step(4 * Frame);
    #1;
    n_cmp++; if (pulse_cnt !== p0 + 4) begin n_fail++; $display("FAIL rep_count: got %0d want %0d", pulse_cnt, p0 + 4); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi();
    test_no_repress();
    test_reset_mid();
`ifdef KEYPAD_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, n_cmp=%0d want completion", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
